serial_deframer: RTL and testbench
==================================

// Module: serial_deframer
// PURPOSE
//  Downstream consumer of the switch-loaded shift register. Takes the bit shifted out (LSB) and the
//  one-cycle shift strobe, and assembles framed serial words. Good frames are latched, counted and
//  shown on two active-low 7-seg digits. Bad framing or a stalled sender raises a one-cycle error.
// PARAMETERS
//  DATA_W       8      payload bits per frame, sent LSB first
//  TIMEOUT_CYC  1024   max clk cycles between strobes inside a frame before abort (>=2)
// PORTS
//  clk         in   1       system clock
//  rst_n       in   1       asynchronous active-low reset
//  bit_in      in   1       serial data bit, sampled only when bit_stb=1
//  bit_stb     in   1       one-cycle pulse per bit, from the edge-detected send key
//  clr         in   1       synchronous clear pulse from the edge-detected reset key
//  data_out    out  DATA_W  last good payload
//  data_valid  out  1       one-cycle pulse when data_out updates
//  frame_err   out  1       one-cycle pulse on framing/parity/timeout error
//  frame_cnt   out  8       count of good frames, wraps 255->0
//  busy        out  1       1 while state != IDLE
//  hex0        out  7       active-low segments of data_out[3:0]
//  hex1        out  7       active-low segments of data_out[7:4]
// BEHAVIOUR
//  - Reset: state=IDLE; data_out=0; data_valid=0; frame_err=0; frame_cnt=0; busy=0; hex0=hex1=7'b1000000.
//  - Frame format: START(1), DATA_W data bits LSB first, [PARITY], STOP(0).
//  - IDLE: bit_stb with bit_in=1 -> DATA, bit index=0. bit_stb with bit_in=0 is line idle and is ignored.
//  - DATA: each strobe shifts bit_in into bit position idx. After bit DATA_W-1 go to PARITY if compiled in,
//    else go to STOP.
//  - PARITY: the strobe bit must equal the even parity of the payload (XOR of data bits); go to STOP either way.
//    The mismatch is remembered.
//  - STOP: strobe bit=0 with no parity mismatch -> good frame. Strobe bit=1 or a mismatch -> frame_err.
//    Both outcomes return to IDLE.
//  - Good frame: on the clk edge after the STOP strobe, data_out<=payload, data_valid=1 for 1 cycle,
//    frame_cnt+=1.
//  - Error: frame_err=1 for 1 cycle on the same edge. data_out, hex and frame_cnt are unchanged.
//  - Timeout: in any state except IDLE, a cycle counter is cleared on every strobe. When it reaches
//    TIMEOUT_CYC-1, frame_err pulses and the block goes to IDLE.
//  - clr has highest priority: state=IDLE, frame_cnt=0, data_out=0. It has no pulses and discards any
//    strobe in the same cycle.
//  - bit_stb asserted on consecutive cycles: each pulse is a distinct bit. No strobe is lost.
//  - hex0/hex1 are registered decodes of data_out and lag it by 1 cycle.
//    Glyphs are 0-9, A, b, C, d, E, F, with g as segment bit 6.
// CONFIGURATION
//  DEFERAMER_PARITY_EN is NOT the name; the macro is SERIAL_DEFRAMER_PARITY_EN.
//  - Defined: the PARITY state exists and a frame is DATA_W+3 strobes.
//  - Undefined: no PARITY state, frame is DATA_W+2 strobes, and a parity error is impossible.
// STRUCTURE
//  - Shared package fpga_lab_pkg holds:
//    - the state enum {IDLE, DATA, PARITY, STOP};
//    - SEG_* 7-bit active-low glyph constants;
//    - the blank/zero glyph.
//  - Sub-module hex7seg (4-bit in, 7-bit active-low out) is instantiated twice. The team reuses it
//    for all display digits.
//  - Index counter width = $clog2(DATA_W). Timeout counter width = $clog2(TIMEOUT_CYC).
// TESTING (DATA_W=8, TIMEOUT_CYC=16)
//  1. Strobe bits 1,1,0,1,0,0,1,0,1,0 (0xA5, no parity).
//     -> data_out=8'hA5 with data_valid for 1 cycle, frame_cnt=1, hex1=0001000, hex0=0010010.
//  2. Same frame but stop bit=1 -> frame_err for 1 cycle, data_out and frame_cnt unchanged, busy=0.
//  3. Send start plus 3 data bits, then no strobes -> frame_err exactly 15 cycles after the last strobe, busy=0.
//  4. With SERIAL_DEFRAMER_PARITY_EN: 0xA5, parity 0, stop 0 -> valid.
//     The same frame with parity 1 -> frame_err, no valid.
//  5. Assert clr mid-DATA with a strobe in the same cycle -> IDLE, frame_cnt=0, data_out=0, no pulses.
//  6. Send 256 good frames back-to-back using 1-cycle-spaced strobes -> frame_cnt wraps to 0 and no frame_err.
```

Correction to CONFIGURATION: the line "DEFERAMER_PARITY_EN is NOT the name; the macro is SERIAL_DEFRAMER_PARITY_EN." should be deleted from the banner. The macro is **SERIAL_DEFRAMER_PARITY_EN**.

Source files
------------

// File: rtl/fpga_lab_pkg.sv
// Shared definitions for the lab blocks: the deframer state encoding and
// active-low seven-segment glyphs (bit 6 = g ... bit 0 = a).
package fpga_lab_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    // A cleared display shows "0" rather than going dark.
    localparam logic [6:0] SEG_ZERO  = SEG_0;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-low seven-segment decoder, reused for
// every display digit.
module hex7seg
    import fpga_lab_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_nibble)
            4'h0: o_seg = SEG_0;
            4'h1: o_seg = SEG_1;
            4'h2: o_seg = SEG_2;
            4'h3: o_seg = SEG_3;
            4'h4: o_seg = SEG_4;
            4'h5: o_seg = SEG_5;
            4'h6: o_seg = SEG_6;
            4'h7: o_seg = SEG_7;
            4'h8: o_seg = SEG_8;
            4'h9: o_seg = SEG_9;
            4'hA: o_seg = SEG_A;
            4'hB: o_seg = SEG_B;
            4'hC: o_seg = SEG_C;
            4'hD: o_seg = SEG_D;
            4'hE: o_seg = SEG_E;
            4'hF: o_seg = SEG_F;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/serial_deframer.sv
// Serial frame receiver: START(1), DATA_W bits LSB first, optional even parity,
// STOP(0). Define SERIAL_DEFRAMER_PARITY_EN to compile in the parity bit.
module serial_deframer
    import fpga_lab_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_in,
    input  logic              bit_stb,
    input  logic              clr,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              frame_err,
    output logic [7:0]        frame_cnt,
    output logic              busy,
    output logic [6:0]        hex0,
    output logic [6:0]        hex1
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
    // Firing one count early makes the error land on the edge where the
    // counter reaches TIMEOUT_CYC-1.
    localparam logic [TMO_W-1:0] TMO_FIRE = TMO_W'(TIMEOUT_CYC - 2);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDX_W-1:0]    r_idx;
    logic [DATA_W-1:0]   r_shift;
    logic [TMO_W-1:0]    r_tcnt;
    logic [DATA_W-1:0]   r_data_out;
    logic                r_data_valid;
    logic                r_frame_err;
    logic [7:0]          r_frame_cnt;
    logic [6:0]          r_hex0;
    logic [6:0]          r_hex1;
    logic                w_good;
    logic                w_err;
    logic                w_tmo_hit;
    logic                w_par_bad;
    logic [7:0]          w_disp;
    logic [6:0]          w_seg0;
    logic [6:0]          w_seg1;

`ifdef SERIAL_DEFRAMER_PARITY_EN
    logic                r_par_err;
    assign w_par_bad = r_par_err;
`else
    assign w_par_bad = 1'b0;
`endif

    assign w_tmo_hit = (r_state != IDLE) && !bit_stb && (r_tcnt == TMO_FIRE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_good      = 1'b0;
        w_err       = 1'b0;
        if (clr) begin
            w_state_nxt = IDLE;
        end else if (w_tmo_hit) begin
            w_err       = 1'b1;
            w_state_nxt = IDLE;
        end else if (bit_stb) begin
            case (r_state)
                IDLE: begin
                    if (bit_in) begin
                        w_state_nxt = DATA;
                    end
                end
                DATA: begin
                    if (r_idx == IDX_LAST) begin
`ifdef SERIAL_DEFRAMER_PARITY_EN
                        w_state_nxt = PARITY;
`else
                        w_state_nxt = STOP;
`endif
                    end
                end
`ifdef SERIAL_DEFRAMER_PARITY_EN
                PARITY: begin
                    w_state_nxt = STOP;
                end
`endif
                STOP: begin
                    if (bit_in || w_par_bad) begin
                        w_err = 1'b1;
                    end else begin
                        w_good = 1'b1;
                    end
                    w_state_nxt = IDLE;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx        <= '0;
            r_shift      <= '0;
            r_tcnt       <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_frame_cnt  <= 8'd0;
`ifdef SERIAL_DEFRAMER_PARITY_EN
            r_par_err    <= 1'b0;
`endif
        end else begin
            r_data_valid <= w_good;
            r_frame_err  <= w_err;
            if (clr) begin
                r_idx       <= '0;
                r_shift     <= '0;
                r_tcnt      <= '0;
                r_data_out  <= '0;
                r_frame_cnt <= 8'd0;
`ifdef SERIAL_DEFRAMER_PARITY_EN
                r_par_err   <= 1'b0;
`endif
            end else begin
                if ((r_state == IDLE) || bit_stb) begin
                    r_tcnt <= '0;
                end else begin
                    r_tcnt <= r_tcnt + TMO_W'(1);
                end
                if (bit_stb) begin
                    case (r_state)
                        IDLE: begin
                            if (bit_in) begin
                                r_idx   <= '0;
                                r_shift <= '0;
`ifdef SERIAL_DEFRAMER_PARITY_EN
                                r_par_err <= 1'b0;
`endif
                            end
                        end
                        DATA: begin
                            r_shift[r_idx] <= bit_in;
                            r_idx          <= r_idx + IDX_W'(1);
                        end
`ifdef SERIAL_DEFRAMER_PARITY_EN
                        PARITY: begin
                            r_par_err <= (bit_in != ^r_shift);
                        end
`endif
                        default: begin
                        end
                    endcase
                end
                if (w_good) begin
                    r_data_out  <= r_shift;
                    r_frame_cnt <= r_frame_cnt + 8'd1;
                end
            end
        end
    end

    // The display always shows the low byte, zero-padding narrow payloads.
    generate
        if (DATA_W >= 8) begin : g_disp_wide
            assign w_disp = r_data_out[7:0];
        end else begin : g_disp_narrow
            assign w_disp = {{(8 - DATA_W){1'b0}}, r_data_out};
        end
    endgenerate

    hex7seg u_hex0 (
        .i_nibble (w_disp[3:0]),
        .o_seg    (w_seg0)
    );

    hex7seg u_hex1 (
        .i_nibble (w_disp[7:4]),
        .o_seg    (w_seg1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hex0 <= SEG_ZERO;
            r_hex1 <= SEG_ZERO;
        end else begin
            r_hex0 <= w_seg0;
            r_hex1 <= w_seg1;
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign frame_err  = r_frame_err;
    assign frame_cnt  = r_frame_cnt;
    assign busy       = (r_state != IDLE);
    assign hex0       = r_hex0;
    assign hex1       = r_hex1;

endmodule

// File: tb/tb_serial_deframer.sv
// Bench for serial_deframer: directed frames, scoreboard of expected
// valid/error pulses, and direct checks of timing, clear and display.
module tb_serial_deframer;

    localparam int DATA_W      = 8;
    localparam int TIMEOUT_CYC = 16;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        bit_in  = 1'b0;
    logic        bit_stb = 1'b0;
    logic        clr     = 1'b0;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        frame_err;
    logic [7:0]  frame_cnt;
    logic        busy;
    logic [6:0]  hex0;
    logic [6:0]  hex1;

    int n_checks = 0;
    int n_fail   = 0;

    // Entry: {is_error, data_out, frame_cnt} expected on the pulse cycle.
    logic [16:0] exp_q[$];
    logic [7:0]  exp_data = 8'h00;
    logic [7:0]  exp_cnt  = 8'h00;

    serial_deframer #(
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_in     (bit_in),
        .bit_stb    (bit_stb),
        .clr        (clr),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .frame_cnt  (frame_cnt),
        .busy       (busy),
        .hex0       (hex0),
        .hex1       (hex1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every valid/error pulse must match the next expected entry.
    always @(negedge clk) begin : monitor
        logic [16:0] e;
        if (rst_n && (data_valid || frame_err)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: got valid=%0b err=%0b data=%0h cnt=%0d expected no pulse",
                         data_valid, frame_err, data_out, frame_cnt);
            end else begin
                e = exp_q.pop_front();
                check("scoreboard_pulse", {15'd0, frame_err, data_out, frame_cnt}, {15'd0, e});
                check("scoreboard_valid", {31'd0, data_valid}, {31'd0, ~e[16]});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bit_in  = b;
        bit_stb = 1'b1;
        step();
        bit_stb = 1'b0;
        bit_in  = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_b);
        logic bad;
        send_bit(1'b1);
        for (int i = 0; i < 8; i++) begin
            send_bit(d[i]);
        end
`ifdef SERIAL_DEFRAMER_PARITY_EN
        send_bit((^d) ^ par_flip);
        bad = stop_b | par_flip;
`else
        bad = stop_b;
`endif
        if (bad) begin
            exp_q.push_back({1'b1, exp_data, exp_cnt});
        end else begin
            exp_cnt  = exp_cnt + 8'd1;
            exp_data = d;
            exp_q.push_back({1'b0, exp_data, exp_cnt});
        end
        send_bit(stop_b);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [7:0] d;

        repeat (3) @(posedge clk);
        #1;
        check("reset_data_out", data_out, 8'h00);
        check("reset_valid", data_valid, 0);
        check("reset_err", frame_err, 0);
        check("reset_cnt", frame_cnt, 0);
        check("reset_busy", busy, 0);
        check("reset_hex0", hex0, 7'b1000000);
        check("reset_hex1", hex1, 7'b1000000);
        rst_n = 1'b1;
        step();

        // Zero strobes in IDLE are idle line.
        send_bit(1'b0);
        send_bit(1'b0);
        check("idle_zero_busy", busy, 0);

        // Good frame 0xA5.
        send_frame(8'hA5, 1'b0, 1'b0);
        check("t1_valid", data_valid, 1);
        check("t1_data", data_out, 8'hA5);
        check("t1_cnt", frame_cnt, 1);
        check("t1_busy", busy, 0);
        step();
        check("t1_valid_drop", data_valid, 0);
        check("t1_hex1", hex1, 7'b0001000);
        check("t1_hex0", hex0, 7'b0010010);

        // Bad stop bit.
        send_frame(8'hA5, 1'b0, 1'b1);
        check("t2_err", frame_err, 1);
        check("t2_valid", data_valid, 0);
        check("t2_data", data_out, 8'hA5);
        check("t2_cnt", frame_cnt, 1);
        check("t2_busy", busy, 0);
        step();
        check("t2_err_drop", frame_err, 0);

        // Stalled sender: start + 3 data bits then silence.
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        exp_q.push_back({1'b1, exp_data, exp_cnt});
        repeat (14) step();
        check("t3_no_err_early", frame_err, 0);
        check("t3_busy_early", busy, 1);
        step();
        check("t3_err", frame_err, 1);
        check("t3_busy", busy, 0);
        step();

        // Recovery after a timeout.
        send_frame(8'h3C, 1'b0, 1'b0);
        check("t3_recover_data", data_out, 8'h3C);
        check("t3_recover_cnt", frame_cnt, 2);

`ifdef SERIAL_DEFRAMER_PARITY_EN
        send_frame(8'hA5, 1'b0, 1'b0);
        check("t4_good_valid", data_valid, 1);
        check("t4_good_cnt", frame_cnt, 3);
        send_frame(8'h5A, 1'b1, 1'b0);
        check("t4_par_err", frame_err, 1);
        check("t4_par_valid", data_valid, 0);
        check("t4_par_data", data_out, 8'hA5);
        check("t4_par_cnt", frame_cnt, 3);
`endif

        // Clear mid-DATA with a coincident strobe.
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        bit_in  = 1'b1;
        bit_stb = 1'b1;
        clr     = 1'b1;
        step();
        bit_stb = 1'b0;
        bit_in  = 1'b0;
        clr     = 1'b0;
        exp_cnt  = 8'h00;
        exp_data = 8'h00;
        check("t5_busy", busy, 0);
        check("t5_cnt", frame_cnt, 0);
        check("t5_data", data_out, 8'h00);
        check("t5_valid", data_valid, 0);
        check("t5_err", frame_err, 0);
        step();
        check("t5_hex0", hex0, 7'b1000000);
        check("t5_hex1", hex1, 7'b1000000);

        // 256 back-to-back frames wrap the counter.
        d = 8'h00;
        for (int i = 0; i < 256; i++) begin
            d = 8'(i * 37) ^ 8'h5A;
            send_frame(d, 1'b0, 1'b0);
        end
        check("t6_cnt_wrap", frame_cnt, 0);
        check("t6_last_data", data_out, d);

        repeat (3) step();
        check("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
